// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry circular FIFO of fetch groups between IFU and decode.
// Full/empty come from the occupancy register so in_ready never depends on out_ready.
module fetch_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DEPTH           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst [FETCH_WIDTH],
  input  logic [INST_ADDR_WIDTH-1:0]   in_pc,
  input  logic [FETCH_WIDTH-1:0]       in_lane_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst [FETCH_WIDTH],
  output logic [INST_ADDR_WIDTH-1:0]   out_pc,
  output logic [INST_ADDR_WIDTH-1:0]   out_pc_next,
  output logic [FETCH_WIDTH-1:0]       out_lane_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [INST_ADDR_WIDTH-1:0] GROUP_BYTES = INST_ADDR_WIDTH'(4 * FETCH_WIDTH);

  logic [31:0]                inst_q       [DEPTH][FETCH_WIDTH];
  logic [INST_ADDR_WIDTH-1:0] pc_q         [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_next_q    [DEPTH];
  logic [FETCH_WIDTH-1:0]     lane_valid_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // Flush wins over any concurrent enqueue/dequeue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq) begin
        count_d = count_q + CW'(1);
      end else if (!enq && deq) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (enq && !flush && !reset) begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        inst_q[wr_ptr_q][l] <= in_inst[l];
      end
      pc_q[wr_ptr_q]         <= in_pc;
      pc_next_q[wr_ptr_q]    <= in_pc + GROUP_BYTES;
      lane_valid_q[wr_ptr_q] <= in_lane_valid;
    end
  end

  always_comb begin
    out_pc         = '0;
    out_pc_next    = '0;
    out_lane_valid = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      out_inst[l] = out_valid ? inst_q[rd_ptr_q][l] : 32'd0;
    end
    if (out_valid) begin
      out_pc         = pc_q[rd_ptr_q];
      out_pc_next    = pc_next_q[rd_ptr_q];
      out_lane_valid = lane_valid_q[rd_ptr_q];
    end
  end

  logic [32*FETCH_WIDTH-1:0] in_inst_flat;
  always_comb begin
    in_inst_flat = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      in_inst_flat[32*l +: 32] = in_inst[l];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= FULL);
    end
  end

  assert property (@(posedge clk) disable iff (reset || flush)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_pc) &&
                                 $stable(in_lane_valid) && $stable(in_inst_flat)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue.
module tb_fetch_queue;
  localparam int FW = 2;
  localparam int AW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_inst  [FW];
  logic [31:0]   out_inst [FW];
  logic [AW-1:0] in_pc, out_pc, out_pc_next;
  logic [FW-1:0] in_lane_valid, out_lane_valid;
  logic [CW-1:0] count;

  fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_lane_valid(out_lane_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    pc;
    logic [FW*32-1:0] inst;
    logic [FW-1:0]    lv;
  } grp_t;

  grp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   synced   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic          enq, deq;
    grp_t          g;
    logic [AW-1:0] pn;
    if (synced) begin
      check("count", 64'(count), 64'(sb.size()));
      check("in_ready", 64'(in_ready), 64'(sb.size() != D));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        g  = sb[0];
        pn = g.pc + AW'(4 * FW);
        check("out_pc", 64'(out_pc), 64'(g.pc));
        check("out_pc_next", 64'(out_pc_next), 64'(pn));
        check("out_lane_valid", 64'(out_lane_valid), 64'(g.lv));
        for (int l = 0; l < FW; l++) check("out_inst", 64'(out_inst[l]), 64'(g.inst[32*l +: 32]));
      end else begin
        check("out_pc_zero", 64'(out_pc), 64'd0);
        check("out_pc_next_zero", 64'(out_pc_next), 64'd0);
        check("out_lane_valid_zero", 64'(out_lane_valid), 64'd0);
        for (int l = 0; l < FW; l++) check("out_inst_zero", 64'(out_inst[l]), 64'd0);
      end
    end
    enq = in_valid && (sb.size() != D);
    deq = out_ready && (sb.size() != 0);
    g.pc = in_pc;
    g.lv = in_lane_valid;
    for (int l = 0; l < FW; l++) g.inst[32*l +: 32] = in_inst[l];
    @(posedge clk);
    if (reset) begin
      sb.delete();
      synced = 1'b1;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back(g);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [AW-1:0] pc, input logic [FW-1:0] lv);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_lane_valid = lv;
    for (int l = 0; l < FW; l++) in_inst[l] = $urandom;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_lane_valid = '0;
    for (int l = 0; l < FW; l++) in_inst[l] = '0;
    @(negedge clk);
    cycle();
    reset = 1'b0;
    cycle();

    // Three groups held, then drained in order
    for (int i = 0; i < 3; i++) begin drive(AW'(i * 8), 2'b11); cycle(); end
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0;

    // Fill, blocked fifth group, one dequeue, fifth accepted last
    for (int i = 0; i < 4; i++) begin drive(AW'(32'h100 + i * 8), 2'b11); cycle(); end
    drive(32'h200, 2'b10);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();

    // Streaming: pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      drive(AW'(32'h1000 + i * 8), FW'($urandom_range(0, 3)));
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b0;

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) begin drive(AW'(32'h2000 + i * 8), 2'b11); cycle(); end
    drive(32'h3000, 2'b11);
    flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();

    // Reset mid-operation, then PC wrap
    for (int i = 0; i < 2; i++) begin drive(AW'(32'h4000 + i * 8), 2'b11); cycle(); end
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    drive(32'hFFFF_FFFC, 2'b11);
    cycle();
    in_valid = 1'b0;
    check("wrap_pc_next", 64'(out_pc_next), 64'h4);
    cycle();
    out_ready = 1'b1;
    repeat (2) cycle();
    out_ready = 1'b0;

    // Partial and empty lane masks
    drive(32'h40, 2'b01);
    cycle();
    drive(32'h48, 2'b00);
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
